// File: rtl/sccb_write_master.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_write_master
//  Purpose  : Three-phase SCCB (I2C-compatible) register write master.
//             Each accepted request sends START, DEV_ADDR, req_addr and
//             req_data (9 bits each, MSB first, 9th bit released), then STOP.
//  Ports    : clk, resetn    - system clock, synchronous active-low reset
//             req_valid/ready, req_addr, req_data - one write per request
//             done           - one-cycle pulse when STOP completes
//             nack           - OR of the three 9th-bit samples
//             scl            - SCCB clock (push-pull)
//             sda_oe, sda_in - open-drain SDA pull-low enable / pad input
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_write_master #(
   parameter int unsigned CLK_DIV  = 60,
   parameter logic [7:0]  DEV_ADDR = 8'h42
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_data,
   output logic       done,
   output logic       nack,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam int unsigned   DW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] c_DIV_MAX = DW'(CLK_DIV - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_BITS  = 2'd2;
   localparam logic [1:0] c_STOP  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [3:0]    bit_q, bit_d;
   logic [1:0]    phase_q, phase_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          nack_q, nack_d;
   logic          scl_q, scl_d;
   logic          sda_oe_q, sda_oe_d;
   logic          w_tick;
   logic          w_done;
   logic [7:0]    w_byte;
   logic          w_bit;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      qtr_d    = qtr_q;
      bit_d    = bit_q;
      phase_d  = phase_q;
      addr_d   = addr_q;
      data_d   = data_q;
      nack_d   = nack_q;
      w_done   = 1'b0;
      w_tick   = (state_q != c_IDLE) && (div_q == c_DIV_MAX);

      if (state_q != c_IDLE) begin
         div_d = w_tick ? '0 : div_q + DW'(1);
      end

      case (state_q)
         c_IDLE: begin
            if (req_valid) begin
               state_d = c_START;
               div_d   = '0;
               qtr_d   = 2'd0;
               bit_d   = 4'd0;
               phase_d = 2'd0;
               addr_d  = req_addr;
               data_d  = req_data;
               nack_d  = 1'b0;
            end
         end
         c_START: begin
            if (w_tick) begin
               if (qtr_q == 2'd1) begin
                  state_d = c_BITS;
                  qtr_d   = 2'd0;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         c_BITS: begin
            if (w_tick) begin
               // ACK slot: slave response sampled at the end of the high-going quarter
               if ((qtr_q == 2'd2) && (bit_q == 4'd8) && sda_in) begin
                  nack_d = 1'b1;
               end
               if (qtr_q == 2'd3) begin
                  qtr_d = 2'd0;
                  if (bit_q == 4'd8) begin
                     bit_d = 4'd0;
                     if (phase_q == 2'd2) begin
                        state_d = c_STOP;
                     end else begin
                        phase_d = phase_q + 2'd1;
                     end
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         default: begin
            if (w_tick) begin
               if (qtr_q == 2'd2) begin
                  state_d = c_IDLE;
                  qtr_d   = 2'd0;
                  w_done  = 1'b1;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
      endcase

      // Bus pins are decoded from the next-state position so they change
      // exactly on the tick that enters each quarter.
      case (phase_d)
         2'd0:    w_byte = DEV_ADDR;
         2'd1:    w_byte = addr_d;
         default: w_byte = data_d;
      endcase
      w_bit = w_byte[3'd7 - bit_d[2:0]];

      case (state_d)
         c_IDLE: begin
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
         end
         c_START: begin
            scl_d    = (qtr_d == 2'd0);
            sda_oe_d = 1'b1;
         end
         c_BITS: begin
            scl_d    = qtr_d[1];
            sda_oe_d = (bit_d == 4'd8) ? 1'b0 : ~w_bit;
         end
         default: begin
            scl_d    = (qtr_d != 2'd0);
            sda_oe_d = (qtr_d != 2'd2);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= c_IDLE;
         div_q    <= '0;
         qtr_q    <= 2'd0;
         bit_q    <= 4'd0;
         phase_q  <= 2'd0;
         addr_q   <= 8'd0;
         data_q   <= 8'd0;
         nack_q   <= 1'b0;
         scl_q    <= 1'b1;
         sda_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         phase_q  <= phase_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         nack_q   <= nack_d;
         scl_q    <= scl_d;
         sda_oe_q <= sda_oe_d;
      end
   end

   assign req_ready = (state_q == c_IDLE);
   assign done      = w_done;
   assign nack      = nack_q;
   assign scl       = scl_q;
   assign sda_oe    = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_write_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sccb_write_master
//  Purpose  : Self-checking bench for sccb_write_master. Three instances
//             (CLK_DIV = 4, 2, 60) share one clock; a per-instance bus
//             monitor decodes START/bits/STOP and flags illegal SDA edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_write_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn    [3];
   logic       req_valid [3];
   logic       req_ready [3];
   logic [7:0] req_addr  [3];
   logic [7:0] req_data  [3];
   logic       done      [3];
   logic       nack      [3];
   logic       scl       [3];
   logic       sda_oe    [3];
   logic       sda_in    [3];
   logic [2:0] resp      [3];   // slave ACK-slot response per phase (1 = NACK)

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc_now  = 0;
   int          done_cnt [3];
   int          accepts  [3];
   int          lat      [3];
   int          viol     [3];
   int          done_time[3];
   int          acc_time [3];
   logic [26:0] bits_out [3];
   logic        nack_at_done[3];
   logic [1:0]  acc_bus  [3];

   always @(posedge clk) cyc_now <= cyc_now + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned DIV = (g == 0) ? 4 : (g == 1) ? 2 : 60;
      int          rise   = 0;
      bit          in_txn = 1'b0;
      bit          timing = 1'b0;
      bit          p_rst  = 1'b0;
      logic        p_scl  = 1'b1;
      logic        p_oe   = 1'b0;
      int          cyc    = 0;
      logic [26:0] bits   = '0;

      sccb_write_master #(.CLK_DIV(DIV), .DEV_ADDR(8'h42)) u_dut (
         .clk       (clk),
         .resetn    (resetn[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .req_data  (req_data[g]),
         .done      (done[g]),
         .nack      (nack[g]),
         .scl       (scl[g]),
         .sda_oe    (sda_oe[g]),
         .sda_in    (sda_in[g])
      );

      assign sda_in[g] = (rise >= 1 && rise <= 27) ? resp[g][(rise - 1) / 9] : 1'b0;

      always @(negedge clk) begin
         if (!resetn[g]) begin
            p_rst  = 1'b0;
            in_txn = 1'b0;
            timing = 1'b0;
            rise   = 0;
         end else if (!p_rst) begin
            p_rst  = 1'b1;
            p_scl  = scl[g];
            p_oe   = sda_oe[g];
         end else begin
            if (timing) cyc++;
            if (done[g]) begin
               done_cnt[g]++;
               lat[g]          = cyc;
               nack_at_done[g] = nack[g];
               bits_out[g]     = bits;
               done_time[g]    = cyc_now;
               timing          = 1'b0;
            end
            if (req_valid[g] && req_ready[g]) begin
               accepts[g]++;
               acc_time[g] = cyc_now;
               acc_bus[g]  = {scl[g], sda_oe[g]};
               timing      = 1'b1;
               cyc         = 0;
            end
            if (scl[g] && !p_scl && in_txn) begin
               rise++;
               if (rise <= 27) bits = {bits[25:0], ~sda_oe[g]};
            end
            if (scl[g] && p_scl && (sda_oe[g] != p_oe)) begin
               if (sda_oe[g]) begin
                  if (in_txn) viol[g]++;
                  in_txn = 1'b1;
                  rise   = 0;
                  bits   = '0;
               end else begin
                  if (!in_txn || rise != 28) viol[g]++;
                  in_txn = 1'b0;
               end
            end
            p_scl = scl[g];
            p_oe  = sda_oe[g];
         end
      end
   end

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 60;
   endfunction

   // Expected wire stream: 27 bits, 9th bit of each byte released (reads 1).
   function automatic logic [26:0] stream(input logic [7:0] a, input logic [7:0] d);
      return {8'h42, 1'b1, a, 1'b1, d, 1'b1};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int k, input int n0);
      int t = 0;
      while (done_cnt[k] == n0 && t < 120 * div_of(k) + 20) begin
         step();
         t++;
      end
      check("done_seen", done_cnt[k] - n0, 1);
   endtask

   task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d,
                           input logic [2:0] r);
      int          n_acc;
      int          n_done;
      int          t = 0;
      logic [31:0] rnd;
      resp[k] = r;
      while (!req_ready[k] && t < 1000) begin
         step();
         t++;
      end
      n_acc  = accepts[k];
      n_done = done_cnt[k];
      req_valid[k] = 1'b1;
      req_addr[k]  = a;
      req_data[k]  = d;
      step();
      req_valid[k] = 1'b0;
      rnd          = $urandom;
      req_addr[k]  = rnd[7:0];
      req_data[k]  = rnd[15:8];
      check("accept", accepts[k] - n_acc, 1);
      check("ready_low", req_ready[k], 0);
      check("nack_clr", nack[k], 0);
      wait_done(k, n_done);
      check("latency", lat[k], 113 * div_of(k));
      check("bits", bits_out[k], stream(a, d));
      check("nack_at_done", nack_at_done[k], |r);
      check("ready_back", req_ready[k], 1);
      check("nack_hold", nack[k], |r);
   endtask

   task automatic busy_test(input int k);
      int a0;
      int d0;
      int t = 0;
      resp[k] = 3'b000;
      a0 = accepts[k];
      d0 = done_cnt[k];
      req_valid[k] = 1'b1;
      req_addr[k]  = 8'hA1;
      req_data[k]  = 8'h1D;
      while (accepts[k] == a0 && t < 100) begin step(); t++; end
      req_addr[k] = 8'h5E;
      req_data[k] = 8'hE7;
      t = 0;
      while (accepts[k] == a0 + 1 && t < 120 * div_of(k)) begin step(); t++; end
      check("busy_second_acc", accepts[k] - a0, 2);
      check("busy_first_done", done_cnt[k] - d0, 1);
      check("busy_acc_gap", acc_time[k] - done_time[k], 1);
      check("busy_idle_bus", acc_bus[k], 2'b10);
      check("busy_bits1", bits_out[k], stream(8'hA1, 8'h1D));
      req_valid[k] = 1'b0;
      wait_done(k, d0 + 1);
      check("busy_bits2", bits_out[k], stream(8'h5E, 8'hE7));
      check("busy_lat2", lat[k], 113 * div_of(k));
      repeat (20) step();
      check("busy_no_third", accepts[k] - a0, 2);
   endtask

   task automatic reset_mid_test(input int k);
      int n_done;
      resp[k] = 3'b000;
      req_valid[k] = 1'b1;
      req_addr[k]  = 8'h5A;
      req_data[k]  = 8'hC3;
      step();
      req_valid[k] = 1'b0;
      n_done = done_cnt[k];
      repeat (40 * div_of(k) - 1) step();
      resetn[k] = 1'b0;
      step();
      resetn[k] = 1'b1;
      check("rst_scl", scl[k], 1);
      check("rst_oe", sda_oe[k], 0);
      check("rst_ready", req_ready[k], 1);
      check("rst_done", done[k], 0);
      repeat (130 * div_of(k)) step();
      check("rst_no_done", done_cnt[k] - n_done, 0);
      do_write(k, 8'h33, 8'hCC, 3'b000);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rnd;
      for (int k = 0; k < 3; k++) begin
         resetn[k]    = 1'b0;
         req_valid[k] = 1'b0;
         req_addr[k]  = 8'h00;
         req_data[k]  = 8'h00;
         resp[k]      = 3'b000;
         done_cnt[k]  = 0;
         accepts[k]   = 0;
         lat[k]       = 0;
         viol[k]      = 0;
         done_time[k] = 0;
         acc_time[k]  = 0;
         bits_out[k]  = '0;
         nack_at_done[k] = 1'b0;
         acc_bus[k]   = 2'b00;
      end
      repeat (3) step();
      for (int k = 0; k < 3; k++) begin
         check("reset_ready", req_ready[k], 1);
         check("reset_done", done[k], 0);
         check("reset_nack", nack[k], 0);
         check("reset_scl", scl[k], 1);
         check("reset_oe", sda_oe[k], 0);
         resetn[k] = 1'b1;
      end
      step();

      do_write(0, 8'h12, 8'h80, 3'b000);
      do_write(0, 8'h12, 8'h80, 3'b111);
      do_write(0, 8'h34, 8'h56, 3'b000);
      do_write(0, 8'hF0, 8'h0F, 3'b010);
      busy_test(0);
      reset_mid_test(0);

      for (int i = 0; i < 50; i++) begin
         rnd = $urandom;
         do_write(1, rnd[7:0], rnd[15:8], rnd[18:16]);
      end
      for (int i = 0; i < 6; i++) begin
         rnd = $urandom;
         do_write(2, rnd[7:0], rnd[15:8], rnd[18:16]);
      end

      for (int k = 0; k < 3; k++) begin
         check("protocol_viol", viol[k], 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sccb_write_master.md
# sccb_write_master

Three-phase SCCB (I2C-compatible) write master that programs the camera sensor's registers over the `scl`/`sda` pins, which are currently tied off in the camera top level. It sits between the configuration sequencer (upstream, one register write per request) and the camera control pins (downstream). It runs from the 48 MHz SB_HFOSC clock domain and drives `sda` open-drain through an SB_IO at the top level.

## Interface
- `CLK_DIV`, default 60: `clk` cycles per SCL quarter-period (48 MHz / (4·60) = 200 kHz); legal values ≥ 2.
- `DEV_ADDR`, default 8'h42: 8-bit SCCB write ID, sent verbatim as phase 1.

- `clk` in 1: system clock, single domain.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: write request present.
- `req_ready` out 1: block can accept a request.
- `req_addr` in 8: sensor sub-address (phase 2).
- `req_data` in 8: register value (phase 3).
- `done` out 1: one-cycle pulse when the STOP condition completes.
- `nack` out 1: OR of the three 9th-bit samples for the last transaction; valid when `done` pulses and held until the next acceptance.
- `scl` out 1: SCCB clock, push-pull.
- `sda_oe` out 1: 1 = pull SDA low; 0 = release (external pull-up → high).
- `sda_in` in 1: SDA pad input.

## Operation
- Reset values: `req_ready`=1, `done`=0, `nack`=0, `scl`=1, `sda_oe`=0, state IDLE, all counters 0.
- Handshake: acceptance happens on a cycle with `req_valid & req_ready`. `req_addr`/`req_data` are latched at that cycle. `req_ready` drops the next cycle and stays low until the cycle after `done`. Requests while `req_ready`=0 are ignored.
- Quarter tick: the divider counter clears on acceptance and ticks when it equals `CLK_DIV-1`, then wraps to 0. All bus changes happen on ticks only.
- States: IDLE → START → BITS → STOP → IDLE.
- **START** (2 quarters):
  - q0: `scl`=1, `sda_oe`=1.
  - q1: `scl`=0, `sda_oe`=1.
- **BITS**: 3 phases (`DEV_ADDR`, `req_addr`, `req_data`) × 9 bits, MSB first, 4 quarters per bit.
  - q0: `scl`=0, SDA set to the new bit.
  - q1: `scl`=0.
  - q2: `scl`=1.
  - q3: `scl`=1.
  - Bits 0–7 drive `sda_oe` = ~bit.
  - Bit 8 (don't-care/ACK): `sda_oe`=0. `sda_in` is sampled at the end of q2; a sample of 1 sets `nack`.
  - Phase counter 0–2 and bit counter 0–8 advance at the end of q3.
- **STOP** (3 quarters):
  - q0: `scl`=0, `sda_oe`=1.
  - q1: `scl`=1, `sda_oe`=1.
  - q2: `scl`=1, `sda_oe`=0.
  - `done` pulses on the cycle the final tick is consumed; the state returns to IDLE on that same cycle.
- `nack` is informational only. The transaction always completes all 3 phases, because SCCB slaves may not ACK.
- Reset mid-transaction: the block immediately returns to reset values (bus released, `scl`=1). No STOP is generated, and no `done` pulse. The next request starts with a normal START.

## Timing
- A transaction is 2 + 108 + 3 = 113 quarters. `done` is high exactly 113·`CLK_DIV` cycles after the acceptance cycle.
- `req_ready` is high again on the cycle after `done`. Back-to-back requests therefore have ≥ 1 idle cycle with `scl`=1 and SDA released between STOP and the next START.
- `scl` and `sda_oe` are registered outputs with no combinational path from inputs.
- SDA only changes while `scl`=0, except for START q0 and STOP q2.

## Test plan
- **Basic write**: `CLK_DIV`=4, reset, request addr=8'h12 data=8'h80 with `sda_in`=0.
  - SDA bit-stream is 42/0, 12/0, 80/0 (MSB first, 9th bit released).
  - `done` arrives at cycle 452 after acceptance; `nack`=0.
- **NACK**: same request with `sda_in` tied 1.
  - All three phases are still sent.
  - `nack`=1 at `done`.
  - `nack` clears on the next acceptance.
- **Busy handshake**: assert `req_valid` continuously with two different payloads.
  - The second payload is accepted only the cycle after the first `done`.
  - Exactly two transactions occur, separated by an idle gap with `scl`=1 and `sda_oe`=0.
- **Reset mid-byte**: drop `resetn` for 1 cycle at quarter 40.
  - Next cycle shows `scl`=1, `sda_oe`=0, `req_ready`=1, and no `done` pulse.
  - A new request then completes normally in 452 cycles.
- **Protocol checker**: a monitor flags any SDA change while `scl`=1 other than START/STOP.
  - Run 50 random addr/data pairs with `CLK_DIV`=2 and `CLK_DIV`=60; zero violations required.
  - Decoded bytes must match the requests.
